vga_timing_engine: RTL and testbench

VGA_TIMING_ENGINE -- requirements
Module: vga_timing_engine

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_delay_line.sv | 37 +++
 rtl/vga_timing_engine.sv | 120 ++++++++++++
 tb/tb_vga_timing_engine.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults, sync polarities and a window-compare helper.
// No logic, no latency, no backpressure.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam logic VGA_HSYNC_POL = 1'b0;
    localparam logic VGA_VSYNC_POL = 1'b0;

    // True when start <= pos < start+len; evaluated in 32 bits so a window ending at 2^COORD_W never truncates.
    function automatic logic in_window(input int pos, input int start, input int len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Strobe-enabled shift register, DEPTH stages of WIDTH bits; DEPTH=0 is a plain wire.
// Latency DEPTH enabled strobes; no backpressure, holds while i_en is low.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_n, i_en};
            assign o_dat    = i_dat;
        end else begin : g_shift
            logic [DEPTH-1:0][WIDTH-1:0] r_stage;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stage <= '0;
                end else if (i_en) begin
                    r_stage[0] <= i_dat;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_dat = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_engine.sv
// VGA raster counters with sync/de delayed PIPE_DELAY strobes behind pix_x/pix_y.
// Advances only on vga_clk strobes; no backpressure, everything holds between strobes.
module vga_timing_engine
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE    = VGA_H_ACTIVE,
    parameter int   H_FP        = VGA_H_FP,
    parameter int   H_SYNC      = VGA_H_SYNC,
    parameter int   H_BP        = VGA_H_BP,
    parameter int   V_ACTIVE    = VGA_V_ACTIVE,
    parameter int   V_FP        = VGA_V_FP,
    parameter int   V_SYNC      = VGA_V_SYNC,
    parameter int   V_BP        = VGA_V_BP,
    parameter logic HSYNC_POL   = VGA_HSYNC_POL,
    parameter logic VSYNC_POL   = VGA_VSYNC_POL,
    parameter int   COORD_W     = 10,
    parameter int   PIPE_DELAY  = 2,
    parameter int   FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vga_clk,
    output logic [COORD_W-1:0]     pix_x,
    output logic [COORD_W-1:0]     pix_y,
    output logic                   hor_sync,
    output logic                   ver_sync,
    output logic                   de,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
            $error("vga_timing_engine: line or frame total does not fit in COORD_W bits");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_delay
            $error("vga_timing_engine: PIPE_DELAY must be within 0..15");
        end
    endgenerate

    logic [COORD_W-1:0]     r_h;
    logic [COORD_W-1:0]     r_v;
    logic                   r_line_start;
    logic                   r_frame_start;
    logic [FRAME_CNT_W-1:0] r_frame_count;

    logic [COORD_W-1:0]     w_h_nxt;
    logic [COORD_W-1:0]     w_v_nxt;
    logic                   w_h_wrap;
    logic                   w_v_wrap;
    logic                   w_hs_raw;
    logic                   w_vs_raw;
    logic                   w_de_raw;
    logic [2:0]             w_dly;

    always_comb begin
        w_h_wrap = (int'(r_h) == H_TOTAL - 1);
        w_v_wrap = (int'(r_v) == V_TOTAL - 1);
        w_h_nxt  = w_h_wrap ? '0 : r_h + COORD_W'(1);
        w_v_nxt  = r_v;
        if (w_h_wrap) begin
            w_v_nxt = w_v_wrap ? '0 : r_v + COORD_W'(1);
        end
    end

    // Raw timing is decoded from the next count so stage 0 of the delay line lines up with pix_x/pix_y.
    always_comb begin
        w_hs_raw = in_window(int'(w_h_nxt), H_ACTIVE + H_FP, H_SYNC);
        w_vs_raw = in_window(int'(w_v_nxt), V_ACTIVE + V_FP, V_SYNC);
        w_de_raw = (int'(w_h_nxt) < H_ACTIVE) && (int'(w_v_nxt) < V_ACTIVE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h           <= '0;
            r_v           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (vga_clk) begin
                r_h           <= w_h_nxt;
                r_v           <= w_v_nxt;
                r_line_start  <= w_h_wrap;
                r_frame_start <= w_h_wrap && w_v_wrap;
                if (w_h_wrap && w_v_wrap) begin
                    r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
                end
            end
        end
    end

    // Sync is carried active-high through the chain so a cleared stage always means "deasserted".
    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_DELAY + 1)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (vga_clk),
        .i_dat ({w_hs_raw, w_vs_raw, w_de_raw}),
        .o_dat (w_dly)
    );

    assign pix_x       = r_h;
    assign pix_y       = r_v;
    assign hor_sync    = w_dly[2] ? HSYNC_POL : ~HSYNC_POL;
    assign ver_sync    = w_dly[1] ? VSYNC_POL : ~VSYNC_POL;
    assign de          = w_dly[0];
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Three small-timing instances (H=8/2/3/1, V=4/1/2/1): A pol0/delay0/4-bit frame count,
// B pol1/delay2, C pol0/delay0 strobed every 4th clk; expected outputs are queued per edge.
module tb_vga_timing_engine;

    typedef struct {
        int h;
        int v;
        int fc;
        logic [15:0] hs;
        logic [15:0] vs;
        logic [15:0] de;
    } mstate_t;

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit de;
        bit ls;
        bit fs;
        int fc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic vck_a, vck_b, vck_c;

    logic [9:0]  px_a, py_a, px_b, py_b, px_c, py_c;
    logic        hs_a, vs_a, de_a, ls_a, fs_a;
    logic        hs_b, vs_b, de_b, ls_b, fs_b;
    logic        hs_c, vs_c, de_c, ls_c, fs_c;
    logic [3:0]  fc_a;
    logic [15:0] fc_b, fc_c;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    mstate_t m_a, m_b, m_c;

    vga_timing_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .COORD_W(10), .PIPE_DELAY(0), .FRAME_CNT_W(4)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .vga_clk(vck_a),
        .pix_x(px_a), .pix_y(py_a), .hor_sync(hs_a), .ver_sync(vs_a), .de(de_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
    );

    vga_timing_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .COORD_W(10), .PIPE_DELAY(2), .FRAME_CNT_W(16)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .vga_clk(vck_b),
        .pix_x(px_b), .pix_y(py_b), .hor_sync(hs_b), .ver_sync(vs_b), .de(de_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
    );

    vga_timing_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .COORD_W(10), .PIPE_DELAY(0), .FRAME_CNT_W(16)
    ) u_dut_c (
        .clk(clk), .rst_n(rst_n), .vga_clk(vck_c),
        .pix_x(px_c), .pix_y(py_c), .hor_sync(hs_c), .ver_sync(vs_c), .de(de_c),
        .line_start(ls_c), .frame_start(fs_c), .frame_count(fc_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: line 14 clks (sync at h=10..12, de h<8), frame 8 lines (sync at v=5..6, de v<4).
    task automatic mstep(inout mstate_t s, input bit rst, input bit stb,
                         input int pd, input bit pol, input int fcw, output exp_t e);
        bit ls = 1'b0;
        bit fs = 1'b0;
        if (rst) begin
            s.h = 0; s.v = 0; s.fc = 0;
            s.hs = '0; s.vs = '0; s.de = '0;
        end else if (stb) begin
            s.h = s.h + 1;
            if (s.h == 14) begin
                s.h = 0;
                s.v = s.v + 1;
                if (s.v == 8) s.v = 0;
            end
            s.hs = {s.hs[14:0], (s.h >= 10 && s.h <= 12)};
            s.vs = {s.vs[14:0], (s.v >= 5 && s.v <= 6)};
            s.de = {s.de[14:0], (s.h < 8 && s.v < 4)};
            ls = (s.h == 0);
            fs = ls && (s.v == 0);
            if (fs) s.fc = (s.fc + 1) % (1 << fcw);
        end
        e.x  = s.h;
        e.y  = s.v;
        e.hs = s.hs[pd] ? pol : !pol;
        e.vs = s.vs[pd] ? pol : !pol;
        e.de = s.de[pd];
        e.ls = ls;
        e.fs = fs;
        e.fc = s.fc;
    endtask

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic cmp_out(input string tag, input exp_t e, input exp_t a);
        n_cmp++;
        if (a.x != e.x || a.y != e.y || a.hs != e.hs || a.vs != e.vs || a.de != e.de ||
            a.ls != e.ls || a.fs != e.fs || a.fc != e.fc) begin
            n_bad++;
            $display("FAIL %s outputs t=%0t: got x=%0d y=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b fc=%0d, expected x=%0d y=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b fc=%0d",
                     tag, $time, a.x, a.y, a.hs, a.vs, a.de, a.ls, a.fs, a.fc,
                     e.x, e.y, e.hs, e.vs, e.de, e.ls, e.fs, e.fc);
        end
    endtask

    // Drive the inputs for the coming edge and queue what that edge must produce.
    task automatic tick(input bit rst);
        exp_t e;
        @(negedge clk);
        #1;
        cyc++;
        rst_n = !rst;
        vck_a = 1'b1;
        vck_b = 1'b1;
        vck_c = (cyc % 4 == 0);
        mstep(m_a, rst, vck_a, 0, 1'b0, 4, e);  q_a.push_back(e);
        mstep(m_b, rst, vck_b, 2, 1'b1, 16, e); q_b.push_back(e);
        mstep(m_c, rst, vck_c, 0, 1'b0, 16, e); q_c.push_back(e);
    endtask

    // Monitor: every edge is an output event for all three instances.
    always @(negedge clk) begin
        exp_t a;
        if (q_a.size() > 0) begin
            a = '{int'(px_a), int'(py_a), hs_a, vs_a, de_a, ls_a, fs_a, int'(fc_a)};
            cmp_out("A", q_a.pop_front(), a);
        end
        if (q_b.size() > 0) begin
            a = '{int'(px_b), int'(py_b), hs_b, vs_b, de_b, ls_b, fs_b, int'(fc_b)};
            cmp_out("B", q_b.pop_front(), a);
        end
        if (q_c.size() > 0) begin
            a = '{int'(px_c), int'(py_c), hs_c, vs_c, de_c, ls_c, fs_c, int'(fc_c)};
            cmp_out("C", q_c.pop_front(), a);
        end
    end

    // Hand-computed frame statistics and edge positions.
    int  wc = 0;
    int  a_fr = 0, a_n = 0, a_hs = 0, a_vs = 0, a_de = 0;
    bit  b_arm = 1'b0, b_de_prev = 1'b0;
    int  c_n = 0, c_last = 0;
    bit  c_fs_prev = 1'b0;

    always @(negedge clk) begin
        wc++;
        if (rst_n !== 1'b1) begin
            a_fr = 0; a_n = 0; a_hs = 0; a_vs = 0; a_de = 0;
            b_arm = 1'b0; b_de_prev = 1'b0;
            c_n = 0; c_fs_prev = 1'b0;
        end else begin
            if (fs_a) begin
                a_fr++;
                check("A frame_count at frame_start", int'(fc_a), a_fr % 16);
                if (a_fr == 2 || a_fr == 3) begin
                    check("A clks per frame", a_n, 112);
                    check("A hsync-low clks per frame", a_hs, 24);
                    check("A vsync-low clks per frame", a_vs, 28);
                    check("A de-high clks per frame", a_de, 32);
                end
                a_n = 0; a_hs = 0; a_vs = 0; a_de = 0;
            end
            a_n++;
            if (!hs_a) a_hs++;
            if (!vs_a) a_vs++;
            if (de_a)  a_de++;

            if (fs_b) b_arm = 1'b1;
            if (b_arm && py_b == 10'd0 && de_b && !b_de_prev)
                check("B de rise pix_x on line 0", int'(px_b), 2);
            if (b_arm && py_b == 10'd0 && !de_b && b_de_prev)
                check("B de fall pix_x on line 0", int'(px_b), 10);
            b_de_prev = de_b;

            if (fs_c) begin
                c_n++;
                if (c_n >= 2) check("C frame_start period clks", wc - c_last, 448);
                check("C frame_start width", int'(c_fs_prev), 0);
                c_last = wc;
            end
            c_fs_prev = fs_c;
        end
    end

    initial begin
        rst_n = 1'b0;
        vck_a = 1'b0;
        vck_b = 1'b0;
        vck_c = 1'b0;
        repeat (3) tick(1'b1);

        check("reset A pix_x", int'(px_a), 0);
        check("reset A hor_sync deasserted", int'(hs_a), 1);
        check("reset B hor_sync deasserted", int'(hs_b), 0);
        check("reset B ver_sync deasserted", int'(vs_b), 0);
        check("reset B de", int'(de_b), 0);
        check("reset C frame_count", int'(fc_c), 0);

        for (int i = 0; i < 2500 && a_fr < 17; i++) tick(1'b0);
        check("A frames reached", a_fr, 17);
        check("A frame_count after 17 frames", int'(fc_a), 1);

        for (int i = 0; i < 300 && !(px_a == 10'd5 && py_a == 10'd2); i++) tick(1'b0);
        check("A at h=5 before reset", int'(px_a), 5);
        check("A at v=2 before reset", int'(py_a), 2);

        tick(1'b1);
        #1;
        check("mid reset A pix_x", int'(px_a), 0);
        check("mid reset A pix_y", int'(py_a), 0);
        check("mid reset A de", int'(de_a), 0);
        check("mid reset A hor_sync", int'(hs_a), 1);
        check("mid reset A ver_sync", int'(vs_a), 1);
        check("mid reset A frame_count", int'(fc_a), 0);
        check("mid reset B hor_sync", int'(hs_b), 0);
        check("mid reset C pix_x", int'(px_c), 0);
        repeat (2) tick(1'b1);

        tick(1'b0);
        @(posedge clk);
        #1;
        check("first strobe A pix_x", int'(px_a), 1);
        check("first strobe A pix_y", int'(py_a), 0);
        check("first strobe A frame_count", int'(fc_a), 0);
        check("first strobe A frame_start", int'(fs_a), 0);

        repeat (600) tick(1'b0);
        @(negedge clk);
        #1;
        check("A queue drained", q_a.size(), 0);
        check("C queue drained", q_c.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
